fft_stage_addr_gen: RTL and testbench

//  Runtime-configurable radix-2 DIT butterfly address sequencer for one FFT layer per run.

---
 rtl/fft_stage_addr_gen.sv | 189 ++++++++++++++++++
 tb/tb_fft_stage_addr_gen.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fft_stage_addr_gen.sv
// Radix-2 DIT butterfly address sequencer: one runtime-selected layer per run, ping-pong banks,
// latency-matched write-back pipeline, CS stall. Optional macro FFT_BITREV_EN: bit-reversed layer-0 reads.
module fft_stage_addr_gen #(
    parameter int FFT_SIZE       = 8,
    parameter int MEM_OFFSET     = FFT_SIZE,
    parameter int ADDR_SIZE      = $clog2(2 * FFT_SIZE),
    parameter int TWID_ADDR_SIZE = 7,
    parameter int BFLY_LATENCY   = 3,
    parameter int LAYER_W        = $clog2($clog2(FFT_SIZE))
) (
    input  logic                      i_CLK,
    input  logic                      i_RST,
    input  logic                      i_CS,
    input  logic                      i_start,
    input  logic [LAYER_W-1:0]        i_layer,
    input  logic                      i_rd_bank,
    output logic                      o_busy,
    output logic                      o_done,
    output logic                      o_err,
    output logic                      o_rden,
    output logic [ADDR_SIZE-1:0]      o_rdaddr_A,
    output logic [ADDR_SIZE-1:0]      o_rdaddr_B,
    output logic [TWID_ADDR_SIZE-1:0] o_rdaddr_tw,
    output logic                      o_wren,
    output logic [ADDR_SIZE-1:0]      o_wraddr_A,
    output logic [ADDR_SIZE-1:0]      o_wraddr_B
);
    localparam int LOG2N    = $clog2(FFT_SIZE);
    localparam int NUM_BFLY = FFT_SIZE / 2;
    localparam int BW       = $clog2(NUM_BFLY);
    localparam int TW_SCALE = (2 ** (TWID_ADDR_SIZE + 1)) / FFT_SIZE;

    typedef enum logic [1:0] {IDLE, READ, DRAIN, DONE} state_t;
    state_t state_reg, state_next;

    logic [BW-1:0]             b_reg;
    logic [LAYER_W-1:0]        layer_reg;
    logic                      bank_reg;
    logic                      err_reg;
    logic                      accept, reject, issue, pipe_busy;

    logic                      rden_reg;
    logic [ADDR_SIZE-1:0]      rdaddr_a_reg, rdaddr_b_reg;
    logic [TWID_ADDR_SIZE-1:0] rdaddr_tw_reg;
    logic [ADDR_SIZE-1:0]      wra_reg, wrb_reg;

    logic                      pipe_valid [BFLY_LATENCY];
    logic [ADDR_SIZE-1:0]      pipe_wa    [BFLY_LATENCY];
    logic [ADDR_SIZE-1:0]      pipe_wb    [BFLY_LATENCY];

    logic [ADDR_SIZE-1:0]      b_wide, h_wide, pos_wide, a_nat, b_nat, a_rd, b_rd;
    logic [ADDR_SIZE-1:0]      rd_base, wr_base;
    logic [TWID_ADDR_SIZE-1:0] tw_addr;

    always_ff @(posedge i_CLK or posedge i_RST) begin
        if (i_RST) begin
            state_reg <= IDLE;
        end else if (i_CS) begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        accept     = 1'b0;
        reject     = 1'b0;
        issue      = 1'b0;
        case (state_reg)
            IDLE: begin
                if (i_start) begin
                    if (32'(i_layer) < LOG2N) begin
                        accept     = 1'b1;
                        state_next = READ;
                    end else begin
                        reject = 1'b1;
                    end
                end
            end
            READ: begin
                issue = 1'b1;
                if (b_reg == BW'(NUM_BFLY - 1)) state_next = DRAIN;
            end
            DRAIN:   if (!pipe_busy) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Pipeline is empty after this edge when only the last stage (now writing) may hold data.
    always_comb begin
        pipe_busy = rden_reg;
        for (int i = 0; i < BFLY_LATENCY - 1; i++) pipe_busy = pipe_busy | pipe_valid[i];
    end

    always_ff @(posedge i_CLK or posedge i_RST) begin
        if (i_RST) begin
            b_reg     <= '0;
            layer_reg <= '0;
            bank_reg  <= 1'b0;
            err_reg   <= 1'b0;
        end else if (i_CS) begin
            err_reg <= reject;
            if (accept) begin
                b_reg     <= '0;
                layer_reg <= i_layer;
                bank_reg  <= i_rd_bank;
            end else if (issue) begin
                b_reg <= b_reg + BW'(1);
            end
        end
    end

    always_comb begin
        b_wide   = ADDR_SIZE'(b_reg);
        h_wide   = ADDR_SIZE'(1) << layer_reg;
        pos_wide = b_wide & (h_wide - ADDR_SIZE'(1));
        a_nat    = (((b_wide >> layer_reg) << layer_reg) << 1) + pos_wide;
        b_nat    = a_nat + h_wide;
        rd_base  = bank_reg ? ADDR_SIZE'(MEM_OFFSET) : '0;
        wr_base  = bank_reg ? '0 : ADDR_SIZE'(MEM_OFFSET);
        tw_addr  = TWID_ADDR_SIZE'(pos_wide) * TWID_ADDR_SIZE'(NUM_BFLY >> layer_reg)
                 * TWID_ADDR_SIZE'(TW_SCALE);
    end

`ifdef FFT_BITREV_EN
    logic [LOG2N-1:0] a_rev, b_rev;
    for (genvar gi = 0; gi < LOG2N; gi++) begin : g_rev
        assign a_rev[gi] = a_nat[LOG2N-1-gi];
        assign b_rev[gi] = b_nat[LOG2N-1-gi];
    end
    assign a_rd = (layer_reg == '0) ? ADDR_SIZE'(a_rev) : a_nat;
    assign b_rd = (layer_reg == '0) ? ADDR_SIZE'(b_rev) : b_nat;
`else
    assign a_rd = a_nat;
    assign b_rd = b_nat;
`endif

    always_ff @(posedge i_CLK or posedge i_RST) begin
        if (i_RST) begin
            rden_reg      <= 1'b0;
            rdaddr_a_reg  <= '0;
            rdaddr_b_reg  <= '0;
            rdaddr_tw_reg <= '0;
            wra_reg       <= '0;
            wrb_reg       <= '0;
        end else if (i_CS) begin
            rden_reg <= issue;
            if (issue) begin
                rdaddr_a_reg  <= rd_base + a_rd;
                rdaddr_b_reg  <= rd_base + b_rd;
                rdaddr_tw_reg <= tw_addr;
                wra_reg       <= wr_base + a_nat;
                wrb_reg       <= wr_base + b_nat;
            end
        end
    end

    // Fed from the issue registers, so the last stage lines up BFLY_LATENCY cycles after o_rden.
    always_ff @(posedge i_CLK or posedge i_RST) begin
        if (i_RST) begin
            for (int i = 0; i < BFLY_LATENCY; i++) begin
                pipe_valid[i] <= 1'b0;
                pipe_wa[i]    <= '0;
                pipe_wb[i]    <= '0;
            end
        end else if (i_CS) begin
            pipe_valid[0] <= rden_reg;
            pipe_wa[0]    <= wra_reg;
            pipe_wb[0]    <= wrb_reg;
            for (int i = 1; i < BFLY_LATENCY; i++) begin
                pipe_valid[i] <= pipe_valid[i-1];
                pipe_wa[i]    <= pipe_wa[i-1];
                pipe_wb[i]    <= pipe_wb[i-1];
            end
        end
    end

    assign o_busy      = (state_reg != IDLE);
    assign o_done      = (state_reg == DONE);
    assign o_err       = err_reg;
    assign o_rden      = rden_reg & i_CS;
    assign o_rdaddr_A  = rdaddr_a_reg;
    assign o_rdaddr_B  = rdaddr_b_reg;
    assign o_rdaddr_tw = rdaddr_tw_reg;
    assign o_wren      = pipe_valid[BFLY_LATENCY-1] & i_CS;
    assign o_wraddr_A  = pipe_wa[BFLY_LATENCY-1];
    assign o_wraddr_B  = pipe_wb[BFLY_LATENCY-1];

endmodule

// File: tb/tb_fft_stage_addr_gen.sv
// Bench for fft_stage_addr_gen: table-driven runs, hand-written stall/error/reset sequences,
// and randomized runs against a pair-enumeration reference model.
module tb_fft_stage_addr_gen;
    localparam int N     = 8;
    localparam int NB    = N / 2;
    localparam int BL    = 3;
    localparam int TWB   = 7;
    localparam int AW    = 4;
    localparam int LW    = 2;
    localparam int LOG2N = 3;
    localparam int OFS   = N;
`ifdef FFT_BITREV_EN
    localparam bit BITREV = 1'b1;
`else
    localparam bit BITREV = 1'b0;
`endif

    logic           clk = 1'b0;
    logic           rst, cs, start, rd_bank;
    logic [LW-1:0]  layer;
    logic           busy, done, err, rden, wren;
    logic [AW-1:0]  ra, rb, wa, wb;
    logic [TWB-1:0] tw;

    fft_stage_addr_gen #(.FFT_SIZE(N), .TWID_ADDR_SIZE(TWB), .BFLY_LATENCY(BL)) dut (
        .i_CLK(clk), .i_RST(rst), .i_CS(cs), .i_start(start), .i_layer(layer),
        .i_rd_bank(rd_bank), .o_busy(busy), .o_done(done), .o_err(err), .o_rden(rden),
        .o_rdaddr_A(ra), .o_rdaddr_B(rb), .o_rdaddr_tw(tw), .o_wren(wren),
        .o_wraddr_A(wa), .o_wraddr_B(wb)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int passes = 0;
    int exp_ra[NB], exp_rb[NB], exp_tw[NB], exp_wa[NB], exp_wb[NB];
    int done_cycle, rden_cnt, wren_cnt;

    typedef struct packed {
        logic [1:0]      layer;
        logic            bank;
        logic [3:0][7:0] ra;
        logic [3:0][7:0] rb;
        logic [3:0][7:0] tw;
        logic [3:0][7:0] wa;
        logic [3:0][7:0] wb;
    } vec_t;
    vec_t tbl [5];

    task automatic chk(input string name, input int act, input int expv);
        checks++;
        if (act == expv) passes++;
        else $display("FAIL %s: got %0d expected %0d", name, act, expv);
    endtask

    function automatic int bitrev(input int x);
        int r = 0;
        for (int i = 0; i < LOG2N; i++)
            if (((x >> i) & 1) == 1) r = r | (1 << (LOG2N - 1 - i));
        return r;
    endfunction

    // b-th butterfly of layer L = b-th index whose bit L is clear, paired with index + 2**L.
    task automatic ref_pair(input int L, input int b, output int a, output int bb, output int t);
        int h   = 1 << L;
        int cnt = 0;
        a = 0;
        for (int i = 0; i < N; i++) begin
            if (((i >> L) & 1) == 0) begin
                if (cnt == b) a = i;
                cnt++;
            end
        end
        bb = a + h;
        t  = ((a % h) * (N / (2 * h)) * ((2 * (1 << TWB)) / N)) % (1 << TWB);
    endtask

    task automatic fill_model(input int L, input int bank);
        int a, bb, t, rbase, wbase;
        rbase = bank ? OFS : 0;
        wbase = bank ? 0 : OFS;
        for (int b = 0; b < NB; b++) begin
            ref_pair(L, b, a, bb, t);
            exp_ra[b] = rbase + ((BITREV && L == 0) ? bitrev(a) : a);
            exp_rb[b] = rbase + ((BITREV && L == 0) ? bitrev(bb) : bb);
            exp_tw[b] = t;
            exp_wa[b] = wbase + a;
            exp_wb[b] = wbase + bb;
        end
    endtask

    task automatic load_row(input int i);
        for (int j = 0; j < NB; j++) begin
            exp_ra[j] = int'(tbl[i].ra[j]);
            exp_rb[j] = int'(tbl[i].rb[j]);
            exp_tw[j] = int'(tbl[i].tw[j]);
            exp_wa[j] = int'(tbl[i].wa[j]);
            exp_wb[j] = int'(tbl[i].wb[j]);
        end
    endtask

    // v counts enabled cycles since accept; the design advances exactly one step per enabled cycle.
    task automatic do_run(input int L, input int bank, input logic [15:0] stall,
                          input bit noisy, input string tag);
        int v = 0;
        int k = 0;
        layer = LW'(L); rd_bank = bank[0]; start = 1'b1; cs = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; layer = ~layer; rd_bank = ~rd_bank;
        done_cycle = -1; rden_cnt = 0; wren_cnt = 0;
        while (v <= NB + BL + 1 && k < 40) begin
            cs = (k < 16) ? !stall[k] : 1'b1;
            if (noisy) begin
                start   = 1'($urandom_range(0, 1));
                layer   = LW'($urandom);
                rd_bank = 1'($urandom_range(0, 1));
            end
            #2;
            chk($sformatf("%s c%0d busy", tag, k), busy, 1);
            chk($sformatf("%s c%0d done", tag, k), done, (v == NB + BL + 1) ? 1 : 0);
            chk($sformatf("%s c%0d err", tag, k), err, 0);
            if (done) done_cycle = k;
            chk($sformatf("%s c%0d rden", tag, k), rden, (cs && v >= 1 && v <= NB) ? 1 : 0);
            if (rden) rden_cnt++;
            if (v >= 1 && v <= NB) begin
                chk($sformatf("%s c%0d rdA", tag, k), ra, exp_ra[v-1]);
                chk($sformatf("%s c%0d rdB", tag, k), rb, exp_rb[v-1]);
                chk($sformatf("%s c%0d tw", tag, k), tw, exp_tw[v-1]);
            end
            chk($sformatf("%s c%0d wren", tag, k), wren, (cs && v >= BL + 1 && v <= NB + BL) ? 1 : 0);
            if (wren) wren_cnt++;
            if (cs && v >= BL + 1 && v <= NB + BL) begin
                chk($sformatf("%s c%0d wrA", tag, k), wa, exp_wa[v-1-BL]);
                chk($sformatf("%s c%0d wrB", tag, k), wb, exp_wb[v-1-BL]);
            end
            @(posedge clk); #1;
            if (cs) v++;
            k++;
        end
        if (v <= NB + BL + 1) chk($sformatf("%s run_timeout", tag), 1, 0);
        start = 1'b0; cs = 1'b1;
        #2;
        chk($sformatf("%s idle busy", tag), busy, 0);
        chk($sformatf("%s idle done", tag), done, 0);
        chk($sformatf("%s rden_count", tag), rden_cnt, NB);
        chk($sformatf("%s wren_count", tag), wren_cnt, NB);
        $display("run %s L=%0d bank=%0d stall=%04h done_cycle=%0d", tag, L, bank, stall, done_cycle);
        @(posedge clk); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0] = '{2'd0, 1'b0,
`ifdef FFT_BITREV_EN
                   {8'd3, 8'd1, 8'd2, 8'd0}, {8'd7, 8'd5, 8'd6, 8'd4},
`else
                   {8'd6, 8'd4, 8'd2, 8'd0}, {8'd7, 8'd5, 8'd3, 8'd1},
`endif
                   32'd0, {8'd14, 8'd12, 8'd10, 8'd8}, {8'd15, 8'd13, 8'd11, 8'd9}};
        tbl[1] = '{2'd1, 1'b0, {8'd5, 8'd4, 8'd1, 8'd0}, {8'd7, 8'd6, 8'd3, 8'd2},
                   {8'd64, 8'd0, 8'd64, 8'd0}, {8'd13, 8'd12, 8'd9, 8'd8}, {8'd15, 8'd14, 8'd11, 8'd10}};
        tbl[2] = '{2'd2, 1'b0, {8'd3, 8'd2, 8'd1, 8'd0}, {8'd7, 8'd6, 8'd5, 8'd4},
                   {8'd96, 8'd64, 8'd32, 8'd0}, {8'd11, 8'd10, 8'd9, 8'd8}, {8'd15, 8'd14, 8'd13, 8'd12}};
        tbl[3] = '{2'd2, 1'b1, {8'd11, 8'd10, 8'd9, 8'd8}, {8'd15, 8'd14, 8'd13, 8'd12},
                   {8'd96, 8'd64, 8'd32, 8'd0}, {8'd3, 8'd2, 8'd1, 8'd0}, {8'd7, 8'd6, 8'd5, 8'd4}};
        tbl[4] = '{2'd1, 1'b1, {8'd13, 8'd12, 8'd9, 8'd8}, {8'd15, 8'd14, 8'd11, 8'd10},
                   {8'd64, 8'd0, 8'd64, 8'd0}, {8'd5, 8'd4, 8'd1, 8'd0}, {8'd7, 8'd6, 8'd3, 8'd2}};

        rst = 1'b1; cs = 1'b1; start = 1'b0; layer = '0; rd_bank = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset busy", busy, 0);   chk("reset done", done, 0);
        chk("reset err", err, 0);     chk("reset rden", rden, 0);
        chk("reset wren", wren, 0);   chk("reset rdA", ra, 0);
        chk("reset rdB", rb, 0);      chk("reset tw", tw, 0);
        chk("reset wrA", wa, 0);      chk("reset wrB", wb, 0);
        rst = 1'b0;
        @(posedge clk); #1;

        for (int i = 0; i < 5; i++) begin
            load_row(i);
            do_run(int'(tbl[i].layer), int'(tbl[i].bank), 16'h0000, 1'b0, $sformatf("tbl%0d", i));
            chk($sformatf("tbl%0d done_cycle", i), done_cycle, NB + BL + 1);
        end

        // Two stalled cycles mid-READ push the done pulse out by two.
        load_row(3);
        do_run(2, 1, 16'h000C, 1'b0, "stall");
        chk("stall done_cycle", done_cycle, NB + BL + 3);

        // Out-of-range layer is rejected with a single error pulse.
        layer = 2'd3; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        chk("err pulse", err, 1);
        chk("err busy", busy, 0);
        chk("err rden", rden, 0);
        @(posedge clk); #1;
        chk("err cleared", err, 0);
        chk("err still idle", busy, 0);
        $display("txn start L=3 rejected");

        // Reset during a run aborts it with no write-back or done.
        layer = 2'd1; rd_bank = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("abort pre rden", rden, 1);
        rst = 1'b1;
        #1;
        chk("abort busy", busy, 0); chk("abort rden", rden, 0);
        chk("abort wren", wren, 0); chk("abort rdA", ra, 0);
        chk("abort rdB", rb, 0);    chk("abort tw", tw, 0);
        chk("abort wrA", wa, 0);    chk("abort wrB", wb, 0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        for (int c = 0; c < 12; c++) begin
            @(posedge clk); #1;
            chk($sformatf("abort c%0d done", c), done, 0);
            chk($sformatf("abort c%0d wren", c), wren, 0);
            chk($sformatf("abort c%0d busy", c), busy, 0);
        end
        $display("txn reset mid-run aborted");

        for (int r = 0; r < 20; r++) begin
            int L, bank;
            logic [15:0] stall;
            L     = $urandom_range(0, LOG2N - 1);
            bank  = $urandom_range(0, 1);
            stall = 16'($urandom & $urandom) & 16'h007F;
            fill_model(L, bank);
            do_run(L, bank, stall, 1'b1, $sformatf("rnd%0d", r));
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
